// File: rtl/iterative_left_shifter_if.sv
// Request/result bundle for iterative_left_shifter.
// master: request producer / result consumer (drives in_*, out_ready).
// slave : the shifter (drives in_ready, out_valid, out_data).
//   in_valid/in_ready : request handshake
//   in_data  [N]      : operand
//   in_amt   [SW]     : requested shift amount, 0..2N-1
//   in_rot            : 0 = logical left shift, 1 = rotate left
//   out_valid/out_ready : result handshake
//   out_data [N]      : result
interface iterative_left_shifter_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N) + 1
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_amt;
  logic          in_rot;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_amt, in_rot, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_rot, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/iterative_left_shifter.sv
// Iterative left shifter / rotator: shifts the captured operand one bit per
// cycle until the effective count is exhausted, then holds the result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : iterative_left_shifter_if slave (request in, result out)
module iterative_left_shifter #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  iterative_left_shifter_if.slave  bus
);

  localparam int unsigned LW = $clog2(N);      // bits of an amount mod N
  localparam int unsigned CW = $clog2(N) + 1;  // count holds 0..N

  // One-hot so the handshake outputs are direct register bits.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    data_q,  data_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            rot_q,   rot_d;

  logic [SW-1:0]   amt;
  logic [CW-1:0]   k_eff;

  assign amt = bus.in_amt;

  // Effective count: saturate at N for logical shifts, wrap mod N for rotates.
  always_comb begin
    k_eff = '0;
    if (bus.in_rot) begin
      k_eff = CW'(amt[LW-1:0]);
    end else if (32'(amt) >= N) begin
      k_eff = CW'(N);
    end else begin
      k_eff = CW'(amt);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          rot_d   = bus.in_rot;
          cnt_d   = k_eff;
          state_d = (k_eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = {data_q[N-2:0], rot_q ? data_q[N-1] : 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = state_q[0];
  assign bus.out_valid = state_q[2];
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_iterative_left_shifter.sv
// Self-checking bench for iterative_left_shifter (N = 8).
module tb_iterative_left_shifter;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 4;
  localparam int MAX_WAIT = 40;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  iterative_left_shifter_if #(.N(N), .SW(SW)) bus ();

  iterative_left_shifter #(.N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] amt;
    logic       rot;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on a 16-bit value.
  function automatic logic [7:0] ref_result(input logic [7:0] d, input int amt, input logic rot);
    logic [15:0] w;
    int k;
    w = {8'h00, d};
    if (rot) begin
      k = amt % 8;
      w = (w << k) | (w >> (8 - k));
      return w[7:0];
    end
    if (amt >= 8) return 8'h00;
    w = w << amt;
    return w[7:0];
  endfunction

  function automatic int ref_latency(input int amt, input logic rot);
    if (rot) return (amt % 8) + 1;
    return ((amt < 8) ? amt : 8) + 1;
  endfunction

  // One full transaction; starts and ends just after a falling edge.
  task automatic run_txn(input logic [7:0] d, input logic [3:0] amt, input logic rot,
                         input logic [7:0] exp_d, input int exp_lat, input int stall);
    int lat;
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < MAX_WAIT) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = amt;
    bus.in_rot    = rot;
    bus.out_ready = (stall == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (!bus.out_valid) return;
    check("result", 32'(bus.out_data), 32'(exp_d));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_hold", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, exp_d});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_xfer_ready_valid", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 2'b10});
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    logic [7:0] rd;
    logic [3:0] ra;
    logic       rr;
    tests = 0;
    fails = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_rot    = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;

    vecs[0]  = '{8'hB5, 4'd3,  1'b0, 8'hA8, 4};
    vecs[1]  = '{8'hB5, 4'd3,  1'b1, 8'hAD, 4};
    vecs[2]  = '{8'h5A, 4'd12, 1'b1, 8'hA5, 5};
    vecs[3]  = '{8'h5A, 4'd0,  1'b0, 8'h5A, 1};
    vecs[4]  = '{8'h5A, 4'd12, 1'b0, 8'h00, 9};
    vecs[5]  = '{8'h5A, 4'd0,  1'b1, 8'h5A, 1};
    vecs[6]  = '{8'h80, 4'd1,  1'b1, 8'h01, 2};
    vecs[7]  = '{8'hFF, 4'd8,  1'b0, 8'h00, 9};
    vecs[8]  = '{8'hFF, 4'd8,  1'b1, 8'hFF, 1};
    vecs[9]  = '{8'h01, 4'd7,  1'b0, 8'h80, 8};
    vecs[10] = '{8'h01, 4'd15, 1'b1, 8'h80, 8};
    vecs[11] = '{8'hC3, 4'd9,  1'b1, 8'h87, 2};

    // Reset values while held.
    #12;
    check("reset_outputs", {21'd0, bus.in_ready, bus.out_valid, bus.out_data},
          {21'd0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].data, vecs[i].amt, vecs[i].rot, vecs[i].exp_data, vecs[i].exp_lat, i % 3);
    end

    // Result held under backpressure while a new request is offered.
    run_txn(8'h3C, 4'd2, 1'b0, 8'hF0, 3, 0);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.in_amt    = 4'd1;
    bus.in_rot    = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    begin
      int w;
      w = 0;
      while (!bus.out_valid && w < MAX_WAIT) begin
        @(negedge clk);
        w++;
      end
    end
    check("bp_first_result", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'h22});
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_amt   = 4'd2;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("bp_hold", {22'd0, bus.in_ready, bus.out_valid, bus.out_data},
            {22'd0, 1'b0, 1'b1, 8'h22});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release", {22'd0, bus.in_ready, bus.out_valid, bus.out_data},
          {22'd0, 1'b1, 1'b0, 8'h22});

    // Asynchronous reset mid-shift aborts the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_amt   = 4'd7;
    bus.in_rot   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("shift_in_progress", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {21'd0, bus.in_ready, bus.out_valid, bus.out_data},
          {21'd0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (bus.out_valid) seen = 1'b1;
      end
      check("no_result_after_abort", 32'(seen), 32'd0);
    end
    bus.out_ready = 1'b0;

    // Randomized against the reference model.
    for (int i = 0; i < 60; i++) begin
      rd = 8'($urandom);
      ra = 4'($urandom_range(0, 15));
      rr = 1'($urandom);
      run_txn(rd, ra, rr, ref_result(rd, int'(ra), rr), ref_latency(int'(ra), rr),
              int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iterative_left_shifter.md
ITERATIVE_LEFT_SHIFTER -- requirements
Module: iterative_left_shifter

Interface
REQ-001 Parameter N, default 8, data width in bits; SHALL be a power of two, N >= 2.
REQ-002 Parameter SW, default $clog2(N)+1, shift-amount width; SHALL allow amounts 0..2N-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_data  input  N  unsigned operand.
REQ-008 in_amt  input  SW  requested shift amount.
REQ-009 in_rot  input  1  0 = logical left shift (zero fill), 1 = rotate left.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  N  result.

Function
REQ-013 Block SHALL implement FSM with states IDLE, SHIFT, DONE; in_ready = (state == IDLE), out_valid = (state == DONE), both decoded from state only.
REQ-014 Transfer in SHALL occur on an edge where in_valid && in_ready; transfer out on an edge where out_valid && out_ready.
REQ-015 On transfer in: data register <= in_data, mode register <= in_rot, count register <= effective count K.
REQ-016 K SHALL be min(in_amt, N) when in_rot = 0, and in_amt mod N when in_rot = 1.
REQ-017 From IDLE on transfer in: next state DONE if K = 0, else SHIFT.
REQ-018 In SHIFT, each cycle: data shifted left by exactly one bit (bit 0 <= 0 for logical, bit 0 <= old bit N-1 for rotate); count decremented; when count = 1 before decrement, next state DONE.
REQ-019 Result SHALL therefore become valid exactly K+1 cycles after the accepting edge.
REQ-020 In DONE, out_data and out_valid SHALL hold stable until transfer out; on transfer out, next state IDLE.
REQ-021 out_data SHALL equal the data register at all times; value is meaningful only while out_valid = 1.
REQ-022 in_valid, in_data, in_amt, in_rot SHALL be ignored while in_ready = 0.
REQ-023 No back-to-back bypass: after transfer out, in_ready asserts the following cycle (minimum one IDLE cycle between results).
REQ-024 Logical shifts with in_amt >= N SHALL yield all-zero result after N shift cycles.

Reset
REQ-025 rst_n = 0 SHALL immediately force state IDLE, data register 0, count 0, mode 0, independent of clk.
REQ-026 During and after reset: in_ready = 1, out_valid = 0, out_data = 0.
REQ-027 Reset asserted in SHIFT or DONE SHALL abort the operation; no result is produced for it.

Verification (N = 8)
REQ-028 in_data 0xB5, in_amt 3, in_rot 0, out_ready 1 -> out_valid rises 4 cycles after accept, out_data 0xA8, then in_ready 1 next cycle.
REQ-029 in_data 0xB5, in_amt 3, in_rot 1 -> out_data 0xAD after 4 cycles; in_data 0x5A, in_amt 12, in_rot 1 -> out_data 0xA5 after 5 cycles.
REQ-030 in_data 0x5A, in_amt 0 -> out_valid the cycle after accept, out_data 0x5A; in_amt 12, in_rot 0 -> out_data 0x00 after 9 cycles.
REQ-031 Result ready, out_ready held 0 for 5 cycles while in_valid = 1 with new operand -> out_valid and out_data constant, in_ready 0, new operand not captured; out_ready 1 -> one transfer, IDLE next cycle.
REQ-032 rst_n pulsed low mid-SHIFT (in_amt 7) between clock edges -> in_ready 1, out_valid 0, out_data 0 immediately; no result appears afterwards.
REQ-033 Bench SHALL compare every result against reference model (a << K truncated, or rotate) for randomized operands, amounts 0..15, both modes, random out_ready stalls.
